audio_tone_player: RTL and testbench

- Generates a square-wave beep pattern on both channels of the Audio_Controller output path: N tone bursts separated by silent gaps.
- Drives left/right_channel_audio_out and write_audio_out, paced only by the controller's audio_out_allowed back-pressure.
- Audio-out counterpart of the clap-detect input path: typically triggered by clapDetected or FSM events in the home-simulation top level.

---
 rtl/audio_out_pkg.sv | 16 +
 rtl/square_wave_gen.sv | 35 +++
 rtl/audio_tone_player.sv | 123 ++++++++++++
 tb/tb_audio_tone_player.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/audio_out_pkg.sv
// rtl/audio_out_pkg.sv - shared types, widths and helpers for the tone output path
package audio_out_pkg;

  localparam int AUDIO_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TONE = 2'd1,
    ST_GAP  = 2'd2
  } tone_state_t;

  function automatic logic [AUDIO_DATA_WIDTH-1:0] twos_neg(input logic [AUDIO_DATA_WIDTH-1:0] v);
    return ~v + {{(AUDIO_DATA_WIDTH-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/square_wave_gen.sv
// rtl/square_wave_gen.sv - square-wave phase/polarity tracker producing one sample per advance
module square_wave_gen import audio_out_pkg::*; #(
  parameter int HALF_PERIOD = 48,
  parameter logic [AUDIO_DATA_WIDTH-1:0] AMPLITUDE = 32'h0800_0000
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        restart,
  input  logic                        advance,
  output logic [AUDIO_DATA_WIDTH-1:0] sample
);

  localparam int PW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(HALF_PERIOD - 1);

  logic [PW-1:0] phase_cnt;
  logic          polarity;  // 0 selects the positive half

  always_ff @(posedge clk) begin
    if (!resetn || restart) begin
      phase_cnt <= '0;
      polarity  <= 1'b0;
    end else if (advance) begin
      if (phase_cnt == PHASE_LAST) begin
        phase_cnt <= '0;
        polarity  <= ~polarity;
      end else begin
        phase_cnt <= phase_cnt + PW'(1);
      end
    end
  end

  assign sample = polarity ? twos_neg(AMPLITUDE) : AMPLITUDE;

endmodule

// File: rtl/audio_tone_player.sv
// rtl/audio_tone_player.sv - beep pattern sequencer feeding the audio controller output FIFO
module audio_tone_player import audio_out_pkg::*; #(
  parameter logic [AUDIO_DATA_WIDTH-1:0] AMPLITUDE = 32'h0800_0000,
  parameter int HALF_PERIOD  = 48,
  parameter int TONE_SAMPLES = 4800,
  parameter int GAP_SAMPLES  = 4800,
  parameter int NUM_BEEPS    = 2
) (
  input  logic                        CLOCK_50,
  input  logic                        resetn,
  input  logic                        start,
  input  logic                        stop,
  input  logic                        audio_out_allowed,
  output logic [AUDIO_DATA_WIDTH-1:0] left_channel_audio_out,
  output logic [AUDIO_DATA_WIDTH-1:0] right_channel_audio_out,
  output logic                        write_audio_out,
  output logic                        busy,
  output logic                        done
);

  localparam int CNT_MAX = (TONE_SAMPLES > GAP_SAMPLES) ? TONE_SAMPLES : GAP_SAMPLES;
  localparam int SW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int BW = (NUM_BEEPS > 1) ? $clog2(NUM_BEEPS) : 1;
  localparam logic [SW-1:0] TONE_LAST = SW'(TONE_SAMPLES - 1);
  localparam logic [SW-1:0] GAP_LAST  = SW'(GAP_SAMPLES - 1);
  localparam logic [BW-1:0] BEEP_LAST = BW'(NUM_BEEPS - 1);

  tone_state_t                 state, state_n;
  logic [SW-1:0]               sample_cnt, sample_cnt_n;
  logic [BW-1:0]               beep_cnt, beep_cnt_n;
  logic                        done_n;
  logic                        wave_restart, wave_advance;
  logic [AUDIO_DATA_WIDTH-1:0] wave_sample;

  square_wave_gen #(
    .HALF_PERIOD(HALF_PERIOD),
    .AMPLITUDE  (AMPLITUDE)
  ) u_wave (
    .clk    (CLOCK_50),
    .resetn (resetn),
    .restart(wave_restart),
    .advance(wave_advance),
    .sample (wave_sample)
  );

  assign busy                    = (state != ST_IDLE);
  assign write_audio_out         = busy & audio_out_allowed & resetn;
  assign left_channel_audio_out  = (state == ST_TONE) ? wave_sample : '0;
  assign right_channel_audio_out = left_channel_audio_out;

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      sample_cnt <= '0;
      beep_cnt   <= '0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      sample_cnt <= sample_cnt_n;
      beep_cnt   <= beep_cnt_n;
      done       <= done_n;
    end
  end

  // Counters only move on a consumed sample; stalled cycles fall through to the defaults.
  always_comb begin
    state_n      = state;
    sample_cnt_n = sample_cnt;
    beep_cnt_n   = beep_cnt;
    done_n       = 1'b0;
    wave_restart = 1'b0;
    wave_advance = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !stop) begin
          state_n      = ST_TONE;
          sample_cnt_n = '0;
          beep_cnt_n   = '0;
          wave_restart = 1'b1;
        end
      end
      ST_TONE: begin
        if (stop) begin
          state_n      = ST_IDLE;
          sample_cnt_n = '0;
          beep_cnt_n   = '0;
        end else if (write_audio_out) begin
          wave_advance = 1'b1;
          if (sample_cnt == TONE_LAST) begin
            sample_cnt_n = '0;
            if (beep_cnt == BEEP_LAST) begin
              state_n    = ST_IDLE;
              beep_cnt_n = '0;
              done_n     = 1'b1;
            end else begin
              state_n = ST_GAP;
            end
          end else begin
            sample_cnt_n = sample_cnt + SW'(1);
          end
        end
      end
      ST_GAP: begin
        if (stop) begin
          state_n      = ST_IDLE;
          sample_cnt_n = '0;
          beep_cnt_n   = '0;
        end else if (write_audio_out) begin
          if (sample_cnt == GAP_LAST) begin
            state_n      = ST_TONE;
            sample_cnt_n = '0;
            beep_cnt_n   = beep_cnt + BW'(1);
            wave_restart = 1'b1;
          end else begin
            sample_cnt_n = sample_cnt + SW'(1);
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_audio_tone_player.sv
// tb/tb_audio_tone_player.sv - self-checking bench for audio_tone_player
module tb_audio_tone_player;

  localparam int HALF = 2;
  localparam int TONE = 6;
  localparam int GAP  = 3;
  localparam logic [31:0] AMP = 32'h100;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [1:0]  start_v = '0;
  logic [1:0]  stop_v = '0;
  logic [1:0]  allowed_v = '0;
  logic [31:0] left_a, right_a, left_b, right_b;
  logic        wr_a, wr_b, busy_a, busy_b, done_a, done_b;
  int          sel = 0;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  always #5 clk = ~clk;

  audio_tone_player #(.AMPLITUDE(AMP), .HALF_PERIOD(HALF), .TONE_SAMPLES(TONE),
                      .GAP_SAMPLES(GAP), .NUM_BEEPS(2)) dut_a (
    .CLOCK_50(clk), .resetn(resetn), .start(start_v[0]), .stop(stop_v[0]),
    .audio_out_allowed(allowed_v[0]), .left_channel_audio_out(left_a),
    .right_channel_audio_out(right_a), .write_audio_out(wr_a), .busy(busy_a), .done(done_a));

  audio_tone_player #(.AMPLITUDE(AMP), .HALF_PERIOD(HALF), .TONE_SAMPLES(TONE),
                      .GAP_SAMPLES(GAP), .NUM_BEEPS(1)) dut_b (
    .CLOCK_50(clk), .resetn(resetn), .start(start_v[1]), .stop(stop_v[1]),
    .audio_out_allowed(allowed_v[1]), .left_channel_audio_out(left_b),
    .right_channel_audio_out(right_b), .write_audio_out(wr_b), .busy(busy_b), .done(done_b));

  logic [31:0] c_left, c_right;
  logic        c_wr, c_busy, c_done;
  assign c_left  = (sel == 1) ? left_b  : left_a;
  assign c_right = (sel == 1) ? right_b : right_a;
  assign c_wr    = (sel == 1) ? wr_b    : wr_a;
  assign c_busy  = (sel == 1) ? busy_b  : busy_a;
  assign c_done  = (sel == 1) ? done_b  : done_a;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference: the ideal sample stream of one complete pattern.
  task automatic build_pattern(input int beeps, output logic [31:0] q[$]);
    logic [31:0] neg_amp;
    neg_amp = 32'd0 - AMP;
    q = {};
    for (int b = 0; b < beeps; b++) begin
      for (int i = 0; i < TONE; i++) q.push_back(((i / HALF) % 2 == 0) ? AMP : neg_amp);
      if (b < beeps - 1)
        for (int g = 0; g < GAP; g++) q.push_back(32'd0);
    end
  endtask

  // mode: 0 always allowed, 1 pattern 1,0,0,1, 2 random. stop_after<0 disables abort.
  task automatic run_pattern(input int s, input string tag, input int mode,
                             input int stop_after, input bit poke);
    logic [31:0] exp_q[$];
    int  idx = 0;
    int  cyc = 0;
    bit  fin = 0;
    bit  stop_prev = 0;
    bit  stop_done = 0;
    bit  stop_now, exp_busy, exp_wr, ended;
    sel = s;
    build_pattern((s == 1) ? 1 : 2, exp_q);
    @(negedge clk);
    start_v[s] = 1'b1; stop_v[s] = 1'b0; allowed_v[s] = 1'b1;
    #1 chk({tag, " idle_write"}, {31'd0, c_wr}, 32'd0);
    ended = 0;
    while (cyc < 400 && !ended) begin
      @(negedge clk);
      start_v[s] = (poke && idx == 3) ? 1'b1 : 1'b0;
      stop_now = (stop_after >= 0 && idx == stop_after && !stop_done);
      if (stop_now) stop_done = 1;
      stop_v[s] = stop_now;
      case (mode)
        0: allowed_v[s] = 1'b1;
        1: allowed_v[s] = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: allowed_v[s] = ($urandom_range(0, 3) != 0);
      endcase
      #1;
      exp_busy = !fin && !stop_prev;
      chk({tag, " busy"}, {31'd0, c_busy}, {31'd0, exp_busy});
      chk({tag, " done"}, {31'd0, c_done}, {31'd0, fin});
      chk({tag, " sample"}, c_left, exp_busy ? exp_q[idx] : 32'd0);
      chk({tag, " right_eq_left"}, c_right, c_left);
      exp_wr = exp_busy && allowed_v[s];
      chk({tag, " write"}, {31'd0, c_wr}, {31'd0, exp_wr});
      if (fin || stop_prev) ended = 1;
      stop_prev = stop_now;
      if (!ended && c_wr && exp_busy) begin
        idx++;
        if (idx == exp_q.size()) fin = 1;
      end
      cyc++;
    end
    if (!ended) chk({tag, " timeout"}, 32'd1, 32'd0);
    start_v[s] = 1'b0; stop_v[s] = 1'b0; allowed_v[s] = 1'b1;
    if (stop_after < 0) chk({tag, " write_total"}, idx, exp_q.size());
    @(negedge clk);
    #1;
    chk({tag, " done_cleared"}, {31'd0, c_done}, 32'd0);
    chk({tag, " idle_after"}, {31'd0, c_busy}, 32'd0);
  endtask

  typedef struct {
    logic        rst, st, sp, al;
    logic        exp_wr, exp_busy_next, exp_done_next;
    logic [31:0] exp_sample_next;
  } vec_t;

  initial begin
    vec_t vecs[9];
    vecs[0] = '{1, 0, 0, 1, 0, 0, 0, 32'h0};
    vecs[1] = '{1, 1, 1, 1, 0, 0, 0, 32'h0};
    vecs[2] = '{0, 1, 0, 1, 0, 0, 0, 32'h0};
    vecs[3] = '{1, 0, 1, 0, 0, 0, 0, 32'h0};
    vecs[4] = '{1, 1, 0, 0, 0, 1, 0, AMP};
    vecs[5] = '{1, 0, 0, 0, 0, 1, 0, AMP};
    vecs[6] = '{1, 0, 1, 1, 1, 0, 0, 32'h0};
    vecs[7] = '{1, 1, 0, 1, 0, 1, 0, AMP};
    vecs[8] = '{0, 0, 0, 1, 0, 0, 0, 32'h0};

    resetn = 1'b0; allowed_v = 2'b11;
    repeat (2) @(negedge clk);
    #1;
    chk("rst busy_a", {31'd0, busy_a}, 32'd0);
    chk("rst busy_b", {31'd0, busy_b}, 32'd0);
    chk("rst write_a", {31'd0, wr_a}, 32'd0);
    chk("rst done_a", {31'd0, done_a}, 32'd0);
    chk("rst left_a", left_a, 32'd0);
    chk("rst right_b", right_b, 32'd0);

    sel = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk($sformatf("vec%0d busy", i - 1), {31'd0, busy_a}, {31'd0, vecs[i-1].exp_busy_next});
        chk($sformatf("vec%0d done", i - 1), {31'd0, done_a}, {31'd0, vecs[i-1].exp_done_next});
        chk($sformatf("vec%0d sample", i - 1), left_a, vecs[i-1].exp_sample_next);
      end
      resetn = vecs[i].rst; start_v[0] = vecs[i].st; stop_v[0] = vecs[i].sp;
      allowed_v[0] = vecs[i].al;
      #1 chk($sformatf("vec%0d write", i), {31'd0, wr_a}, {31'd0, vecs[i].exp_wr});
    end
    @(negedge clk);
    chk("vec8 busy", {31'd0, busy_a}, 32'd0);
    chk("vec8 sample", left_a, 32'd0);
    resetn = 1'b1; start_v = '0; stop_v = '0; allowed_v = 2'b11;
    @(negedge clk);

    run_pattern(0, "basic", 0, -1, 0);
    run_pattern(0, "backpressure", 1, -1, 0);
    run_pattern(0, "abort", 0, 4, 0);
    run_pattern(0, "replay", 0, -1, 0);

    sel = 0;
    @(negedge clk);
    start_v[0] = 1'b1; allowed_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (7) @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("gaprst busy_before", {31'd0, busy_a}, 32'd1);
    chk("gaprst in_gap", left_a, 32'd0);
    chk("gaprst write_gated", {31'd0, wr_a}, 32'd0);
    @(negedge clk);
    resetn = 1'b1; allowed_v[0] = 1'b0;
    #1;
    chk("gaprst busy", {31'd0, busy_a}, 32'd0);
    chk("gaprst out", left_a, 32'd0);
    chk("gaprst done", {31'd0, done_a}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      #1 chk("gaprst no_done", {31'd0, done_a}, 32'd0);
    end
    allowed_v[0] = 1'b1;
    run_pattern(0, "after_reset", 0, -1, 0);

    run_pattern(0, "start_in_tone", 0, -1, 1);
    @(negedge clk);
    start_v[0] = 1'b1; stop_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0; stop_v[0] = 1'b0;
    #1 chk("start_stop_idle busy", {31'd0, busy_a}, 32'd0);

    for (int r = 0; r < 3; r++) run_pattern(0, $sformatf("random%0d", r), 2, -1, 0);
    run_pattern(0, "random_abort", 2, 8, 0);
    run_pattern(1, "one_beep", 0, -1, 0);
    run_pattern(1, "one_beep_random", 2, -1, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
